// File: rtl/add_iter_pkg.sv
// Shared types and helpers for the iterative adder sequencer.
package add_iter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // Counter wide enough to hold the values 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/add_iter_ctrl_halfadder.sv
// Shared W-bit bitwise half-adder datapath: sum = a ^ b, carry = a & b per bit.
module add_iter_ctrl_halfadder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/add_iter_ctrl.sv
// Sequencer performing full W-bit addition by iterating a shared bitwise half-adder
// until the shifted carry vector is zero.
module add_iter_ctrl
  import add_iter_pkg::*;
#(
  parameter int unsigned W  = DefaultWidth,
  parameter int unsigned CW = cnt_width(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_cout,
  output logic [CW-1:0] out_iters,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cy_q, cy_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [W-1:0]  out_sum_q, out_sum_d;
  logic          out_cout_q, out_cout_d;
  logic [CW-1:0] out_iters_q, out_iters_d;
  logic          out_valid_q, out_valid_d;

  logic [W-1:0]  ha_sum;
  logic [W-1:0]  ha_carry;
  logic [W-1:0]  b_shift;
  logic [CW-1:0] iter_inc;
  logic          cy_next;

  add_iter_ctrl_halfadder #(
    .W (W)
  ) u_halfadder (
    .a_i     (a_q),
    .b_i     (b_q),
    .sum_o   (ha_sum),
    .carry_o (ha_carry)
  );

  assign b_shift  = {ha_carry[W-2:0], 1'b0};
  assign iter_inc = iter_q + CW'(1);
  // Carry out of the top bit is sticky: it leaves the datapath and never returns.
  assign cy_next  = cy_q | ha_carry[W-1];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cy_d        = cy_q;
    iter_d      = iter_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_iters_d = out_iters_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cy_d    = 1'b0;
          iter_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d    = ha_sum;
        b_d    = b_shift;
        cy_d   = cy_next;
        iter_d = iter_inc;
        // The pass-count cap only guards against a broken datapath.
        if (b_shift == '0 || iter_inc == CW'(W)) begin
          state_d     = StDone;
          out_sum_d   = ha_sum;
          out_cout_d  = cy_next;
          out_iters_d = iter_inc;
          out_valid_d = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      cy_q        <= 1'b0;
      iter_q      <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_iters_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cy_q        <= cy_d;
      iter_q      <= iter_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_iters_q <= out_iters_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_iters = out_iters_q;

endmodule

// File: tb/tb_add_iter_ctrl.sv
// Scoreboard bench for add_iter_ctrl: expected results queued at accept, compared at handshake.
module tb_add_iter_ctrl;
  import add_iter_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = cnt_width(W);

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic [CW-1:0] iters;
    int            acc_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic [CW-1:0] out_iters;
  logic          busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  exp_t sb[$];
  logic prev_valid = 1'b0;

  add_iter_ctrl #(
    .W  (W),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_iters (out_iters),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: ripple addition for the result, carry-propagation rounds for the pass count.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0]   full;
    logic [W-1:0] x, y, c;
    int           n;
    full = {1'b0, a} + {1'b0, b};
    x = a;
    y = b;
    n = 0;
    do begin
      c = x & y;
      x = x ^ y;
      y = c << 1;
      n++;
    end while (y != '0 && n < int'(W));
    e.sum     = full[W-1:0];
    e.cout    = full[W];
    e.iters   = CW'(n);
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e = model(a, b);
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Output monitor: latency on the rising edge of out_valid, data at the handshake.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].iters));
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("sum", 32'(out_sum), 32'(e.sum));
        check("cout", 32'(out_cout), 32'(e.cout));
        check("iters", 32'(out_iters), 32'(e.iters));
        check("iters_range", 32'(out_iters >= CW'(1) && out_iters <= CW'(W)), 32'd1);
      end
      // The pass-count cap may only end a run whose shifted carry is already zero.
      if (dut.state_q == StRun && dut.iter_q == CW'(W - 1)) begin
        check("cap_with_carry", 32'(dut.ha_carry[W-2:0]), 32'd0);
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_out_iters", 32'(out_iters), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    send(8'd5, 8'd6);
    send(8'd250, 8'd7);
    send(8'd255, 8'd1);
    send(8'd150, 8'd2);
    send(8'd0, 8'd0);
    wait_drain(100);

    // Backpressure: result held, input ignored while DONE
    rdy_mode = 2;
    send(8'd7, 8'd6);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        in_a     = 8'd1;
        in_b     = 8'd1;
      end else begin
        in_valid = 1'b0;
      end
      #2;
      check("bp_sum_hold", 32'(out_sum), 32'd13);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_busy", 32'(busy), 32'd1);
    rdy_mode = 0;
    wait_drain(20);
    send(8'd1, 8'd1);
    wait_drain(20);

    // Reset in the middle of a run
    send(8'd255, 8'd1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd5, 8'd95);
    wait_drain(20);

    // Random operands with random consumer stalls
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom), W'($urandom));
    end
    wait_drain(200);
    rdy_mode = 0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
